// File: rtl/memwb_stage.sv
// Memory / writeback stage: issues data-BRAM and accelerator-bus accesses and
// retires every writeback source through one fixed-latency in-order pipe.
module memwb_stage #(
  parameter int DATA_W      = 16,
  parameter int DADDR_W     = 11,
  parameter int REG_W       = 4,
  parameter int BUS_ADDR_W  = 3,
  parameter int MEM_LAT     = 1,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_alutoreg,
  input  logic                  ex_memtoreg,
  input  logic                  ex_bustoreg,
  input  logic                  ex_memread,
  input  logic                  ex_memwrite,
  input  logic                  ex_buswrite,
  input  logic                  ex_halt,
  input  logic [DATA_W-1:0]     ex_alu_out,
  input  logic [DATA_W-1:0]     ex_data2,
  input  logic [REG_W-1:0]      ex_dest,
  input  logic [BUS_ADDR_W-1:0] ex_bus_addr,
  output logic                  dmem_ren,
  output logic                  dmem_wren,
  output logic [DADDR_W-1:0]    dmem_addr,
  output logic [DATA_W-1:0]     dmem_data_to,
  input  logic [DATA_W-1:0]     dmem_data_from,
  output logic                  bus_wr,
  output logic                  bus_rd,
  output logic [BUS_ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  stall,
  output logic                  wb_en,
  output logic [REG_W-1:0]      wb_dest,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  halt,
  output logic                  bus_err
);

  localparam int CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam int LAST  = MEM_LAT - 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_halt;
  logic                    r_err;
  logic [BUS_ADDR_W-1:0]   r_bus_addr;

  // Retire pipe: slot 0 is written on accept, slot LAST drives the register file.
  logic                    r_vld_p  [MEM_LAT];
  logic                    r_load_p [MEM_LAT];
  logic [REG_W-1:0]        r_dest_p [MEM_LAT];
  logic [DATA_W-1:0]       r_pay_p  [MEM_LAT];

  logic                    w_active;
  logic                    w_idle_acc;
  logic                    w_push;
  logic                    w_push_load;
  logic [DATA_W-1:0]       w_push_pay;
  logic                    w_bus_rd;
  logic                    w_stall;
  logic                    w_timeout;

  // Side effects are only permitted while running, out of reset, and not waiting on the bus.
  assign w_active   = !r_halt && !rst;
  assign w_idle_acc = w_active && (r_state == S_IDLE);

  // Bus-read FSM next state, retire-pipe push selection and stall generation.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_load = 1'b0;
    w_push_pay  = '0;
    w_bus_rd    = 1'b0;
    w_stall     = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_active) begin
          if (ex_memtoreg) begin
            // A store issued alongside a load suppresses the load's writeback.
            if (!ex_memwrite) begin
              w_push      = 1'b1;
              w_push_load = 1'b1;
            end
          end else if (ex_bustoreg) begin
            w_bus_rd = 1'b1;
            if (bus_ack) begin
              w_push     = 1'b1;
              w_push_pay = bus_rdata;
            end else begin
              w_stall     = 1'b1;
              w_state_nxt = S_WAIT;
            end
          end else if (ex_alutoreg) begin
            w_push     = 1'b1;
            w_push_pay = ex_alu_out;
          end
        end
      end
      S_WAIT: begin
        if (!w_active) begin
          // Halt abandons the outstanding read without a writeback.
          w_state_nxt = S_IDLE;
        end else begin
          w_bus_rd = 1'b1;
          if (bus_ack) begin
            w_push      = 1'b1;
            w_push_pay  = bus_rdata;
            w_state_nxt = S_IDLE;
          end else if (r_cnt == CNT_W'(BUS_TIMEOUT)) begin
            w_push      = 1'b1;
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stall = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, wait counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_halt  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT))
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;
      if (ex_halt)
        r_halt <= 1'b1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  // Capture the bus address while idle so it is held for the whole wait.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE)
      r_bus_addr <= ex_bus_addr;
  end

  // Retire-pipe valid bits: a bubble enters whenever nothing is pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++)
        r_vld_p[i] <= 1'b0;
    end else begin
      r_vld_p[0] <= w_push;
      for (int i = 1; i < MEM_LAT; i++)
        r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  // Retire-pipe payload; qualified by the valid bits so it needs no reset.
  always_ff @(posedge clk) begin
    r_load_p[0] <= w_push_load;
    r_dest_p[0] <= ex_dest;
    r_pay_p[0]  <= w_push_pay;
    for (int i = 1; i < MEM_LAT; i++) begin
      r_load_p[i] <= r_load_p[i-1];
      r_dest_p[i] <= r_dest_p[i-1];
      r_pay_p[i]  <= r_pay_p[i-1];
    end
  end

  assign dmem_ren     = w_idle_acc && ex_memread && !ex_memwrite;
  assign dmem_wren    = w_idle_acc && ex_memwrite;
  assign dmem_addr    = ex_alu_out[DADDR_W-1:0];
  assign dmem_data_to = ex_data2;

  assign bus_rd    = w_bus_rd;
  assign bus_wr    = w_idle_acc && ex_buswrite;
  assign bus_wdata = bus_wr ? ex_data2 : '0;
  assign bus_addr  = w_bus_rd ? ((r_state == S_WAIT) ? r_bus_addr : ex_bus_addr)
                              : (bus_wr ? ex_bus_addr : '0);
  assign stall     = w_stall;

  // Load data arrives from the BRAM exactly when its slot reaches the end of the pipe.
  assign wb_en   = r_vld_p[LAST];
  assign wb_dest = r_vld_p[LAST] ? r_dest_p[LAST] : '0;
  assign wb_data = !r_vld_p[LAST] ? '0 :
                   (r_load_p[LAST] ? dmem_data_from : r_pay_p[LAST]);

  assign halt    = r_halt;
  assign bus_err = r_err;

endmodule

// File: tb/tb_memwb_stage.sv
// Directed testbench for memwb_stage with MEM_LAT=2 and BUS_TIMEOUT=4.
module tb_memwb_stage;
  localparam int DATA_W = 16, DADDR_W = 11, REG_W = 4, BUS_ADDR_W = 3;
  localparam int MEM_LAT = 2, BUS_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  logic ex_alutoreg, ex_memtoreg, ex_bustoreg, ex_memread, ex_memwrite, ex_buswrite, ex_halt;
  logic [DATA_W-1:0] ex_alu_out, ex_data2;
  logic [REG_W-1:0] ex_dest;
  logic [BUS_ADDR_W-1:0] ex_bus_addr;
  logic dmem_ren, dmem_wren;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_data_to, dmem_data_from;
  logic bus_wr, bus_rd, bus_ack;
  logic [BUS_ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata, bus_rdata;
  logic stall, wb_en, halt, bus_err;
  logic [REG_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  memwb_stage #(.DATA_W(DATA_W), .DADDR_W(DADDR_W), .REG_W(REG_W), .BUS_ADDR_W(BUS_ADDR_W),
                .MEM_LAT(MEM_LAT), .BUS_TIMEOUT(BUS_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_alutoreg(ex_alutoreg), .ex_memtoreg(ex_memtoreg), .ex_bustoreg(ex_bustoreg),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_buswrite(ex_buswrite),
    .ex_halt(ex_halt), .ex_alu_out(ex_alu_out), .ex_data2(ex_data2), .ex_dest(ex_dest),
    .ex_bus_addr(ex_bus_addr), .dmem_ren(dmem_ren), .dmem_wren(dmem_wren),
    .dmem_addr(dmem_addr), .dmem_data_to(dmem_data_to), .dmem_data_from(dmem_data_from),
    .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall(stall), .wb_en(wb_en),
    .wb_dest(wb_dest), .wb_data(wb_data), .halt(halt), .bus_err(bus_err)
  );

  // BRAM model with a two-cycle read latency; location 0x010 preloaded with 0xBEEF on reset.
  logic [DATA_W-1:0] mem [2**DADDR_W];
  logic [DATA_W-1:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    rd_p1 <= mem[dmem_addr];
    rd_p2 <= rd_p1;
    if (rst) mem[11'h010] <= 16'hBEEF;
    else if (dmem_wren) mem[dmem_addr] <= dmem_data_to;
  end
  assign dmem_data_from = rd_p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_alutoreg = 0; ex_memtoreg = 0; ex_bustoreg = 0; ex_memread = 0;
    ex_memwrite = 0; ex_buswrite = 0; ex_halt = 0;
    ex_alu_out = '0; ex_data2 = '0; ex_dest = '0; ex_bus_addr = '0;
    bus_ack = 0; bus_rdata = '0;
  endtask

  task automatic do_reset();
    tick(); idle(); rst = 1;
    tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    tick(); tick(); rst = 0; #1;
    n_checks++; if (wb_en !== 1'b0) begin n_errors++; $display("FAIL reset_wb_en got=%b exp=0", wb_en); end
    n_checks++; if (wb_dest !== '0 || wb_data !== '0) begin n_errors++; $display("FAIL reset_wb got=%h/%h exp=0/0", wb_dest, wb_data); end
    n_checks++; if (halt !== 1'b0 || bus_err !== 1'b0) begin n_errors++; $display("FAIL reset_flags got=%b%b exp=00", halt, bus_err); end
    n_checks++; if ({stall, bus_rd, bus_wr, dmem_ren, dmem_wren} !== 5'b0) begin n_errors++; $display("FAIL reset_strobes got=%b exp=00000", {stall, bus_rd, bus_wr, dmem_ren, dmem_wren}); end
  endtask

  task automatic test_alu_load();
    tick(); idle(); ex_alutoreg = 1; ex_dest = 4'd3; ex_alu_out = 16'h1234; #1;
    n_checks++; if (wb_en !== 1'b0 || dmem_ren !== 1'b0) begin n_errors++; $display("FAIL alu_issue got=%b%b exp=00", wb_en, dmem_ren); end
    tick(); idle(); ex_memtoreg = 1; ex_memread = 1; ex_dest = 4'd5; ex_alu_out = 16'h0010; #1;
    n_checks++; if (dmem_ren !== 1'b1 || dmem_addr !== 11'h010) begin n_errors++; $display("FAIL load_issue got=%b/%h exp=1/010", dmem_ren, dmem_addr); end
    n_checks++; if (wb_en !== 1'b0) begin n_errors++; $display("FAIL alu_early_wb got=%b exp=0", wb_en); end
    tick(); idle(); #1;
    n_checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd3 || wb_data !== 16'h1234) begin n_errors++; $display("FAIL alu_wb got=%b/%h/%h exp=1/3/1234", wb_en, wb_dest, wb_data); end
    tick(); #1;
    n_checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd5 || wb_data !== 16'hBEEF) begin n_errors++; $display("FAIL load_wb got=%b/%h/%h exp=1/5/beef", wb_en, wb_dest, wb_data); end
    tick(); #1;
    n_checks++; if (wb_en !== 1'b0) begin n_errors++; $display("FAIL load_wb_once got=%b exp=0", wb_en); end
  endtask

  task automatic test_bus_read_ack();
    int n_stall = 0;
    int n_rd = 0;
    for (int c = 0; c < 5; c++) begin
      tick(); idle();
      if (c < 4) begin ex_bustoreg = 1; ex_dest = 4'd7; ex_bus_addr = 3'd5; end
      if (c == 3) begin bus_ack = 1; bus_rdata = 16'h00A5; end
      #1;
      if (stall) n_stall++;
      if (bus_rd) n_rd++;
      if (c == 2) begin
        n_checks++; if (bus_addr !== 3'd5) begin n_errors++; $display("FAIL busrd_addr got=%h exp=5", bus_addr); end
      end
      if (c == 4) begin
        n_checks++; if (wb_en !== 1'b0) begin n_errors++; $display("FAIL busrd_early_wb got=%b exp=0", wb_en); end
      end
    end
    n_checks++; if (n_stall != 3) begin n_errors++; $display("FAIL busrd_stall_cycles got=%0d exp=3", n_stall); end
    n_checks++; if (n_rd != 4) begin n_errors++; $display("FAIL busrd_rd_cycles got=%0d exp=4", n_rd); end
    tick(); #1;
    n_checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd7 || wb_data !== 16'h00A5) begin n_errors++; $display("FAIL busrd_wb got=%b/%h/%h exp=1/7/00a5", wb_en, wb_dest, wb_data); end
  endtask

  task automatic test_timeout();
    int n_stall = 0;
    int n_rd = 0;
    for (int c = 0; c < 7; c++) begin
      tick(); idle();
      if (c < 6) begin ex_bustoreg = 1; ex_dest = 4'd9; ex_alu_out = 16'hFFFF; end
      #1;
      if (stall) n_stall++;
      if (bus_rd) n_rd++;
      if (c == 5) begin
        n_checks++; if (bus_err !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL tmo_last_wait got err/stall=%b%b exp=00", bus_err, stall); end
      end
      if (c == 6) begin
        n_checks++; if (bus_err !== 1'b1) begin n_errors++; $display("FAIL tmo_bus_err got=%b exp=1", bus_err); end
      end
    end
    n_checks++; if (n_stall != 5) begin n_errors++; $display("FAIL tmo_stall_cycles got=%0d exp=5", n_stall); end
    n_checks++; if (n_rd != 6) begin n_errors++; $display("FAIL tmo_rd_cycles got=%0d exp=6", n_rd); end
    tick(); #1;
    n_checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd9 || wb_data !== 16'h0000) begin n_errors++; $display("FAIL tmo_wb got=%b/%h/%h exp=1/9/0000", wb_en, wb_dest, wb_data); end
  endtask

  task automatic test_memrw_conflict();
    tick(); idle(); ex_memtoreg = 1; ex_memread = 1; ex_memwrite = 1; ex_dest = 4'd2;
    ex_alu_out = 16'h0020; ex_data2 = 16'h5555; #1;
    n_checks++; if (dmem_wren !== 1'b1 || dmem_ren !== 1'b0 || dmem_data_to !== 16'h5555) begin n_errors++; $display("FAIL rw_strobes got=%b%b/%h exp=10/5555", dmem_wren, dmem_ren, dmem_data_to); end
    tick(); idle(); #1;
    tick(); #1;
    n_checks++; if (wb_en !== 1'b0) begin n_errors++; $display("FAIL rw_no_wb got=%b exp=0", wb_en); end
    tick(); ex_memtoreg = 1; ex_memread = 1; ex_dest = 4'd4; ex_alu_out = 16'h0020; #1;
    tick(); idle(); #1;
    tick(); #1;
    n_checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd4 || wb_data !== 16'h5555) begin n_errors++; $display("FAIL rw_readback got=%b/%h/%h exp=1/4/5555", wb_en, wb_dest, wb_data); end
  endtask

  task automatic test_bus_write();
    tick(); idle(); ex_buswrite = 1; ex_bus_addr = 3'd3; ex_data2 = 16'h7777; #1;
    n_checks++; if (bus_wr !== 1'b1 || bus_wdata !== 16'h7777 || bus_addr !== 3'd3 || stall !== 1'b0) begin n_errors++; $display("FAIL buswr got=%b/%h/%h/%b exp=1/7777/3/0", bus_wr, bus_wdata, bus_addr, stall); end
    tick(); idle(); #1;
    n_checks++; if (bus_wr !== 1'b0 || bus_wdata !== 16'h0000) begin n_errors++; $display("FAIL buswr_drop got=%b/%h exp=0/0000", bus_wr, bus_wdata); end
    tick(); #1;
    n_checks++; if (wb_en !== 1'b0) begin n_errors++; $display("FAIL buswr_no_wb got=%b exp=0", wb_en); end
  endtask

  task automatic test_rst_during_wait();
    tick(); idle(); ex_bustoreg = 1; ex_dest = 4'd6; #1;
    tick(); #1;
    n_checks++; if (stall !== 1'b1 || bus_rd !== 1'b1) begin n_errors++; $display("FAIL rstw_waiting got=%b%b exp=11", stall, bus_rd); end
    tick(); idle(); rst = 1; #1;
    tick(); rst = 0; #1;
    n_checks++; if ({bus_rd, stall, bus_err, halt, wb_en, dmem_ren, dmem_wren, bus_wr} !== 8'b0) begin n_errors++; $display("FAIL rstw_outputs got=%b exp=00000000", {bus_rd, stall, bus_err, halt, wb_en, dmem_ren, dmem_wren, bus_wr}); end
    n_checks++; if (bus_addr !== '0 || wb_dest !== '0 || wb_data !== '0) begin n_errors++; $display("FAIL rstw_buses got=%h/%h/%h exp=0/0/0", bus_addr, wb_dest, wb_data); end
    tick(); ex_bustoreg = 1; ex_dest = 4'd6; bus_ack = 1; bus_rdata = 16'h0042; #1;
    n_checks++; if (bus_rd !== 1'b1 || stall !== 1'b0) begin n_errors++; $display("FAIL rstw_idle_after got=%b%b exp=10", bus_rd, stall); end
    tick(); idle(); #1;
    tick(); #1;
    n_checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd6 || wb_data !== 16'h0042) begin n_errors++; $display("FAIL rstw_same_cycle_ack got=%b/%h/%h exp=1/6/0042", wb_en, wb_dest, wb_data); end
    tick(); idle(); ex_alutoreg = 1; ex_dest = 4'd1; ex_alu_out = 16'h1111; #1;
    tick(); idle(); rst = 1; #1;
    tick(); rst = 0; #1;
    n_checks++; if (wb_en !== 1'b0) begin n_errors++; $display("FAIL rst_discard got=%b exp=0", wb_en); end
  endtask

  task automatic test_halt();
    tick(); idle(); ex_memtoreg = 1; ex_memread = 1; ex_dest = 4'd5; ex_alu_out = 16'h0010; #1;
    tick(); idle(); ex_halt = 1; #1;
    n_checks++; if (halt !== 1'b0) begin n_errors++; $display("FAIL halt_early got=%b exp=0", halt); end
    tick(); idle(); ex_memwrite = 1; ex_alu_out = 16'h0030; ex_data2 = 16'h9999; #1;
    n_checks++; if (halt !== 1'b1 || dmem_wren !== 1'b0) begin n_errors++; $display("FAIL halt_store got=%b%b exp=10", halt, dmem_wren); end
    n_checks++; if (wb_en !== 1'b1 || wb_dest !== 4'd5 || wb_data !== 16'hBEEF) begin n_errors++; $display("FAIL halt_inflight_wb got=%b/%h/%h exp=1/5/beef", wb_en, wb_dest, wb_data); end
    tick(); idle(); ex_bustoreg = 1; ex_dest = 4'd2; #1;
    n_checks++; if (bus_rd !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL halt_busrd got=%b%b exp=00", bus_rd, stall); end
    tick(); idle(); ex_alutoreg = 1; ex_dest = 4'd1; ex_alu_out = 16'h2222; #1;
    tick(); idle(); #1;
    tick(); #1;
    n_checks++; if (wb_en !== 1'b0) begin n_errors++; $display("FAIL halt_no_accept got=%b exp=0", wb_en); end
  endtask

  task automatic test_halt_during_wait();
    do_reset();
    tick(); idle(); ex_bustoreg = 1; ex_dest = 4'd8; #1;
    tick(); ex_halt = 1; #1;
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL hw_waiting got=%b exp=1", stall); end
    tick(); ex_halt = 0; bus_ack = 1; bus_rdata = 16'h0BAD; #1;
    n_checks++; if (halt !== 1'b1 || bus_rd !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL hw_abort got=%b%b%b exp=100", halt, bus_rd, stall); end
    tick(); idle(); #1;
    tick(); #1;
    n_checks++; if (wb_en !== 1'b0 || bus_err !== 1'b0) begin n_errors++; $display("FAIL hw_no_push got=%b err=%b exp=0/0", wb_en, bus_err); end
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_alu_load();
    test_bus_read_ack();
    test_memrw_conflict();
    test_bus_write();
    test_timeout();
    test_rst_during_wait();
    test_halt();
    test_halt_during_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
